// File: rtl/clarvi_pio_irq.sv
// clarvi_pio_irq: Avalon-MM GPIO slave with set/clear output access,
// synchronised + debounced inputs, edge capture and a maskable level irq.
//
// Bus handshake: there is no waitrequest, so every avs_read/avs_write strobe
// is accepted in the cycle it is presented. A read returns its data on
// avs_readdata together with a one-cycle avs_readdatavalid pulse exactly one
// cycle later. A simultaneous read and write both take effect, and the read
// returns the register contents from before the write.
module clarvi_pio_irq #(
  parameter int               OUT_W           = 8,
  parameter int               IN_W            = 1,
  parameter logic [OUT_W-1:0] OUT_RESET       = '0,
  parameter int               DEBOUNCE_CYCLES = 50000
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [2:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  input  logic [IN_W-1:0]   pio_in,
  output logic [OUT_W-1:0]  pio_out,
  output logic              irq
);

  // Word addresses of the register map.
  localparam logic [2:0] ADDR_DATA_OUT = 3'd0;
  localparam logic [2:0] ADDR_OUT_SET  = 3'd1;
  localparam logic [2:0] ADDR_OUT_CLR  = 3'd2;
  localparam logic [2:0] ADDR_DATA_IN  = 3'd3;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd4;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd5;
  localparam logic [2:0] ADDR_RISE_EN  = 3'd6;
  localparam logic [2:0] ADDR_FALL_EN  = 3'd7;

  // A counter of at least one bit keeps DEBOUNCE_CYCLES == 1 legal; its
  // terminal value is then 0, so a differing sample is accepted at once.
  localparam int               CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [IN_W-1:0]  sync_meta;
  logic [IN_W-1:0]  sync_s;
  logic [IN_W-1:0]  stable;
  logic [CNT_W-1:0] cnt [IN_W];
  logic [IN_W-1:0]  accept;
  logic [IN_W-1:0]  cap_set;
  logic [IN_W-1:0]  cap_clr;
  logic [IN_W-1:0]  edge_cap;
  logic [IN_W-1:0]  irq_mask;
  logic [IN_W-1:0]  rise_en;
  logic [IN_W-1:0]  fall_en;
  logic [31:0]      rd_mux;
  logic             wr_edge_cap;

  // Write data bits above the port widths are intentionally ignored.
  logic unused_wdata;
  assign unused_wdata = ^avs_writedata;

  // Two-flop synchroniser for the asynchronous inputs.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync_meta <= '0;
      sync_s    <= '0;
    end else begin
      sync_meta <= pio_in;
      sync_s    <= sync_meta;
    end
  end

  // A bit is accepted when it has differed from the stable value for the full window.
  always_comb begin
    accept = '0;
    for (int i = 0; i < IN_W; i++) begin
      accept[i] = (sync_s[i] != stable[i]) && (cnt[i] == CNT_MAX);
    end
  end

  // Per-bit debounce: any sample equal to stable restarts the count.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      stable <= '0;
      for (int i = 0; i < IN_W; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < IN_W; i++) begin
        if (sync_s[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          stable[i] <= sync_s[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Edge detection on accepted transitions and write-one-to-clear mask.
  assign cap_set     = accept & ((sync_s & rise_en) | (~sync_s & fall_en));
  assign wr_edge_cap = avs_write && (avs_address == ADDR_EDGE_CAP);
  assign cap_clr     = wr_edge_cap ? avs_writedata[IN_W-1:0] : '0;

  // Sticky capture; a new edge on the same bit beats a coincident clear.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      edge_cap <= '0;
    end else begin
      edge_cap <= (edge_cap & ~cap_clr) | cap_set;
    end
  end

  // Output data and control register writes, including atomic set/clear.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pio_out  <= OUT_RESET;
      irq_mask <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
    end else if (avs_write) begin
      case (avs_address)
        ADDR_DATA_OUT: pio_out  <= avs_writedata[OUT_W-1:0];
        ADDR_OUT_SET:  pio_out  <= pio_out | avs_writedata[OUT_W-1:0];
        ADDR_OUT_CLR:  pio_out  <= pio_out & ~avs_writedata[OUT_W-1:0];
        ADDR_IRQ_MASK: irq_mask <= avs_writedata[IN_W-1:0];
        ADDR_RISE_EN:  rise_en  <= avs_writedata[IN_W-1:0];
        ADDR_FALL_EN:  fall_en  <= avs_writedata[IN_W-1:0];
        default: ;
      endcase
    end
  end

  // Read mux over pre-write register values; unused upper bits read as zero.
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_DATA_OUT: rd_mux = 32'(pio_out);
      ADDR_DATA_IN:  rd_mux = 32'(stable);
      ADDR_EDGE_CAP: rd_mux = 32'(edge_cap);
      ADDR_IRQ_MASK: rd_mux = 32'(irq_mask);
      ADDR_RISE_EN:  rd_mux = 32'(rise_en);
      ADDR_FALL_EN:  rd_mux = 32'(fall_en);
      default:       rd_mux = '0;
    endcase
  end

  // Fixed one-cycle read latency.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= avs_read;
      if (avs_read) begin
        avs_readdata <= rd_mux;
      end
    end
  end

  assign irq = |(edge_cap & irq_mask);

endmodule
